// File: rtl/knn_pkg.sv
// knn_pkg: shared definitions for the KNN vote classifier.
//   state_t  : controller states IDLE / COUNT / RESOLVE / DONE
//   clog2    : ceiling log2 for use in parameter/port widths
//   CLASSES  : class count for the default label width
package knn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int TYPE_W_DEF = 3;
    localparam int CLASSES    = 1 << TYPE_W_DEF;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/knn_class_tally.sv
// knn_class_tally: per-class vote counter bank with optional distance-sum bank.
//   Optional feature macro: TIE_BREAK_DIST_EN (adds the dsum bank and its ports).
// Ports:
//   clk, rst          clock, async active-low reset
//   i_clear           clear every tally (start of a new vector)
//   i_inc             add one vote to class i_inc_idx
//   i_inc_idx         class receiving the vote
//   i_inc_dist        distance added to that class's dsum (macro only)
//   i_rd_idx          class being read
//   o_rd_cnt          vote count of class i_rd_idx
//   o_rd_dsum         distance sum of class i_rd_idx (macro only)
module knn_class_tally #(
    parameter int TYPE_W = 3,
    parameter int CNT_W  = 3
`ifdef TIE_BREAK_DIST_EN
    ,
    parameter int DIST_W = 16,
    parameter int DSUM_W = 19
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_inc,
    input  logic [TYPE_W-1:0] i_inc_idx,
`ifdef TIE_BREAK_DIST_EN
    input  logic [DIST_W-1:0] i_inc_dist,
    output logic [DSUM_W-1:0] o_rd_dsum,
`endif
    input  logic [TYPE_W-1:0] i_rd_idx,
    output logic [CNT_W-1:0]  o_rd_cnt
);

    localparam int C = 1 << TYPE_W;

    logic [CNT_W-1:0] r_cnt [C];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < C; c++) r_cnt[c] <= '0;
        end else if (i_clear) begin
            for (int c = 0; c < C; c++) r_cnt[c] <= '0;
        end else if (i_inc) begin
            r_cnt[i_inc_idx] <= r_cnt[i_inc_idx] + CNT_W'(1);
        end
    end

    assign o_rd_cnt = r_cnt[i_rd_idx];

`ifdef TIE_BREAK_DIST_EN
    logic [DSUM_W-1:0] r_dsum [C];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < C; c++) r_dsum[c] <= '0;
        end else if (i_clear) begin
            for (int c = 0; c < C; c++) r_dsum[c] <= '0;
        end else if (i_inc) begin
            r_dsum[i_inc_idx] <= r_dsum[i_inc_idx] + DSUM_W'(i_inc_dist);
        end
    end

    assign o_rd_dsum = r_dsum[i_rd_idx];
`endif

endmodule

// File: rtl/knn_vote_classifier.sv
// knn_vote_classifier: majority vote over the K nearest entries of a sorted
// (distance, label) vector, result offered on a valid/ready handshake.
//   Optional feature macro: TIE_BREAK_DIST_EN (equal votes resolved by the
//   smaller distance sum, then lower class index; otherwise lower index wins).
// Ports:
//   clk, rst            clock, async active-low reset
//   in_valid/in_ready   vector handshake; in_ready high only while idle
//   ascending           1: nearest entry at index 0, 0: nearest at index N-1
//   in, in_type         packed distances / labels, entry i in slice i
//   out_class/out_votes winning class and its vote count
//   out_valid/out_ready result handshake; result held until accepted
//
// state   | meaning
// IDLE    | waiting for a vector, in_ready=1
// COUNT   | tallying one captured entry per cycle, K cycles
// RESOLVE | scanning classes 0..C-1, one per cycle, keeping the best
// DONE    | result presented, waiting for out_ready
module knn_vote_classifier
    import knn_pkg::*;
#(
    parameter int L      = 5,
    parameter int W      = 16,
    parameter int TYPE_W = 3,
    parameter int K      = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        ascending,
    input  logic [W*(1<<L)-1:0]         in,
    input  logic [TYPE_W*(1<<L)-1:0]    in_type,
    output logic [TYPE_W-1:0]           out_class,
    output logic [clog2(K+1)-1:0]       out_votes,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int N      = 1 << L;
    localparam int C      = 1 << TYPE_W;
    localparam int CNT_W  = clog2(K + 1);
    localparam int MAX_KC = (K > C) ? K : C;
    localparam int TMR_W  = (clog2(MAX_KC) < 1) ? 1 : clog2(MAX_KC);

    generate
        if (K < 1 || K > N) begin : g_bad_k
            $error("knn_vote_classifier: K must be in 1..N");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TMR_W-1:0]   r_tmr;
    logic [TYPE_W-1:0]  r_cls;
    logic [TYPE_W-1:0]  r_best_class;
    logic [CNT_W-1:0]   r_best_cnt;
    logic [TYPE_W-1:0]  r_type [K];
    logic [TYPE_W-1:0]  w_near_type [K];
    logic [CNT_W-1:0]   w_rd_cnt;
    logic               w_capture;
    logic               w_tc;
    logic               w_take;
    logic               w_in_ready;

    // Entries beyond the K nearest are never voted on.
    logic               w_unused_bits;
    assign w_unused_bits = ^{in, in_type};

    // Reorder into nearest-first so COUNT always consumes slot 0.
    for (genvar g = 0; g < K; g++) begin : g_pick_type
        assign w_near_type[g] = ascending ? in_type[TYPE_W*g +: TYPE_W]
                                          : in_type[TYPE_W*(N-1-g) +: TYPE_W];
    end

`ifdef TIE_BREAK_DIST_EN
    localparam int DSUM_W = W + CNT_W;

    logic [W-1:0]       r_dist [K];
    logic [W-1:0]       w_near_dist [K];
    logic [DSUM_W-1:0]  r_best_dsum;
    logic [DSUM_W-1:0]  w_rd_dsum;

    for (genvar g = 0; g < K; g++) begin : g_pick_dist
        assign w_near_dist[g] = ascending ? in[W*g +: W] : in[W*(N-1-g) +: W];
    end
`endif

    assign w_capture = in_valid && w_in_ready;
    assign w_tc      = (r_tmr == '0);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = COUNT;
            COUNT:   if (w_tc)     w_state_nxt = RESOLVE;
            RESOLVE: if (w_tc)     w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_in_ready = 1'b0;
        out_valid  = 1'b0;
        case (r_state)
            IDLE:    w_in_ready = 1'b1;
            DONE:    out_valid  = 1'b1;
            default: ;
        endcase
    end

    assign in_ready  = w_in_ready;
    assign out_class = r_best_class;
    assign out_votes = r_best_cnt;

    // Best starts at cnt 0, so a zero-vote class can never displace a voted one.
    always_comb begin
        w_take = 1'b0;
        if (w_rd_cnt > r_best_cnt) begin
            w_take = 1'b1;
        end
`ifdef TIE_BREAK_DIST_EN
        else if (w_rd_cnt == r_best_cnt && w_rd_dsum < r_best_dsum) begin
            w_take = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmr        <= '0;
            r_cls        <= '0;
            r_best_class <= '0;
            r_best_cnt   <= '0;
            for (int j = 0; j < K; j++) r_type[j] <= '0;
`ifdef TIE_BREAK_DIST_EN
            r_best_dsum  <= '0;
            for (int j = 0; j < K; j++) r_dist[j] <= '0;
`endif
        end else if (w_capture) begin
            r_tmr        <= TMR_W'(K - 1);
            r_cls        <= '0;
            r_best_class <= '0;
            r_best_cnt   <= '0;
            for (int j = 0; j < K; j++) r_type[j] <= w_near_type[j];
`ifdef TIE_BREAK_DIST_EN
            r_best_dsum  <= '0;
            for (int j = 0; j < K; j++) r_dist[j] <= w_near_dist[j];
`endif
        end else begin
            case (r_state)
                COUNT: begin
                    for (int j = 0; j < K - 1; j++) r_type[j] <= r_type[j+1];
`ifdef TIE_BREAK_DIST_EN
                    for (int j = 0; j < K - 1; j++) r_dist[j] <= r_dist[j+1];
`endif
                    if (w_tc) begin
                        r_tmr <= TMR_W'(C - 1);
                        r_cls <= '0;
                    end else begin
                        r_tmr <= r_tmr - TMR_W'(1);
                    end
                end
                RESOLVE: begin
                    if (w_take) begin
                        r_best_class <= r_cls;
                        r_best_cnt   <= w_rd_cnt;
`ifdef TIE_BREAK_DIST_EN
                        r_best_dsum  <= w_rd_dsum;
`endif
                    end
                    r_cls <= r_cls + TYPE_W'(1);
                    if (!w_tc) r_tmr <= r_tmr - TMR_W'(1);
                end
                default: ;
            endcase
        end
    end

    knn_class_tally #(
        .TYPE_W (TYPE_W),
        .CNT_W  (CNT_W)
`ifdef TIE_BREAK_DIST_EN
        ,
        .DIST_W (W),
        .DSUM_W (DSUM_W)
`endif
    ) u_tally (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_capture),
        .i_inc      (r_state == COUNT),
        .i_inc_idx  (r_type[0]),
`ifdef TIE_BREAK_DIST_EN
        .i_inc_dist (r_dist[0]),
        .o_rd_dsum  (w_rd_dsum),
`endif
        .i_rd_idx   (r_cls),
        .o_rd_cnt   (w_rd_cnt)
    );

endmodule

// File: tb/tb_knn_vote_classifier.sv
module tb_knn_vote_classifier;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // K=5 instance
    logic         v5_in_valid = 1'b0, v5_asc = 1'b1, v5_out_ready = 1'b0;
    logic [127:0] v5_in = '0;
    logic [23:0]  v5_type = '0;
    logic         w5_in_ready, w5_out_valid;
    logic [2:0]   w5_class, w5_votes;

    // K=4 instance
    logic         v4_in_valid = 1'b0, v4_asc = 1'b1, v4_out_ready = 1'b0;
    logic [127:0] v4_in = '0;
    logic [23:0]  v4_type = '0;
    logic         w4_in_ready, w4_out_valid;
    logic [2:0]   w4_class, w4_votes;

    knn_vote_classifier #(.L(3), .W(16), .TYPE_W(3), .K(5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(v5_in_valid), .in_ready(w5_in_ready),
        .ascending(v5_asc), .in(v5_in), .in_type(v5_type),
        .out_class(w5_class), .out_votes(w5_votes), .out_valid(w5_out_valid),
        .out_ready(v5_out_ready));

    knn_vote_classifier #(.L(3), .W(16), .TYPE_W(3), .K(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4_in_valid), .in_ready(w4_in_ready),
        .ascending(v4_asc), .in(v4_in), .in_type(v4_type),
        .out_class(w4_class), .out_votes(w4_votes), .out_valid(w4_out_valid),
        .out_ready(v4_out_ready));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    typedef struct {
        bit           asc;
        logic [23:0]  ty;
        logic [127:0] d;
        int           cls;
        int           votes;
    } vec_t;

    function automatic logic [127:0] ramp(input bit asc);
        logic [127:0] r;
        for (int i = 0; i < 8; i++)
            r[16*i +: 16] = asc ? 16'(10 * (i + 1)) : 16'(10 * (8 - i));
        return r;
    endfunction

    // Reference: take the k nearest, find the top vote count, then pick among
    // the classes holding it by the tie rule.
    function automatic void model(input bit asc, input logic [23:0] ty,
                                  input logic [127:0] d, input int k,
                                  output int cls, output int votes);
        int cnt[8];
        int ds[8];
        int top;
        for (int c = 0; c < 8; c++) begin cnt[c] = 0; ds[c] = 0; end
        for (int j = 0; j < k; j++) begin
            int idx;
            int c;
            idx = asc ? j : 7 - j;
            c = int'(ty[3*idx +: 3]);
            cnt[c] = cnt[c] + 1;
            ds[c] = ds[c] + int'(d[16*idx +: 16]);
        end
        top = 0;
        for (int c = 0; c < 8; c++) if (cnt[c] > top) top = cnt[c];
        cls = -1;
        for (int c = 0; c < 8; c++) begin
            if (cnt[c] == top) begin
`ifdef TIE_BREAK_DIST_EN
                if (cls < 0 || ds[c] < ds[cls]) cls = c;
`else
                if (cls < 0) cls = c;
`endif
            end
        end
        votes = top;
    endfunction

    // Offer a vector to dut5, scramble inputs after capture, check latency and
    // result, optionally stall out_ready, then complete the handshake.
    task automatic run5(input bit asc, input logic [23:0] ty, input logic [127:0] d,
                        input int ecls, input int evotes, input string nm, input int hold);
        int guard;
        int cyc;
        v5_asc = asc; v5_type = ty; v5_in = d; v5_in_valid = 1'b1;
        guard = 0;
        while (!w5_in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        if (guard >= 50) chk({nm, " in_ready timeout"}, 0, 1);
        @(posedge clk); #1;
        v5_in_valid = 1'b0;
        v5_asc = ~asc;
        v5_type = 24'($urandom);
        v5_in = {$urandom, $urandom, $urandom, $urandom};
        cyc = 1;
        while (!w5_out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
        chk({nm, " latency"}, cyc, 14);
        chk({nm, " class"}, int'(w5_class), ecls);
        chk({nm, " votes"}, int'(w5_votes), evotes);
        if (hold > 0) begin
            repeat (hold) begin @(posedge clk); #1; end
            chk({nm, " held class"}, int'(w5_class), ecls);
        end
        v5_out_ready = 1'b1;
        @(posedge clk); #1;
        v5_out_ready = 1'b0;
        chk({nm, " valid drop"}, int'(w5_out_valid), 0);
        chk({nm, " ready back"}, int'(w5_in_ready), 1);
    endtask

    vec_t tbl[7];

    initial begin
        int ec;
        int ev;
        int cyc;
        int guard;

`ifdef TIE_BREAK_DIST_EN
        tbl[2] = '{1'b1, {3'd7,3'd7,3'd7,3'd5,3'd1,3'd3,3'd1,3'd3},
                   {16'd200,16'd200,16'd200,16'd150,16'd100,16'd2,16'd100,16'd1}, 3, 2};
        tbl[3] = '{1'b1, {3'd7,3'd7,3'd7,3'd0,3'd1,3'd2,3'd3,3'd4}, ramp(1'b1), 4, 1};
`else
        tbl[2] = '{1'b1, {3'd7,3'd7,3'd7,3'd5,3'd1,3'd3,3'd1,3'd3},
                   {16'd200,16'd200,16'd200,16'd150,16'd100,16'd2,16'd100,16'd1}, 1, 2};
        tbl[3] = '{1'b1, {3'd7,3'd7,3'd7,3'd0,3'd1,3'd2,3'd3,3'd4}, ramp(1'b1), 0, 1};
`endif
        tbl[0] = '{1'b1, {3'd7,3'd7,3'd7,3'd2,3'd3,3'd1,3'd2,3'd2}, ramp(1'b1), 2, 3};
        tbl[1] = '{1'b0, {3'd6,3'd6,3'd0,3'd6,3'd5,3'd0,3'd0,3'd0}, ramp(1'b0), 6, 3};
        tbl[4] = '{1'b0, {3'd7,3'd7,3'd7,3'd7,3'd7,3'd1,3'd1,3'd1}, ramp(1'b0), 7, 5};
        tbl[5] = '{1'b1, {3'd0,3'd0,3'd0,3'd7,3'd2,3'd5,3'd2,3'd5},
                   {16'd60,16'd50,16'd40,16'd30,16'd10,16'd20,16'd20,16'd10}, 2, 2};
        tbl[6] = '{1'b1, {3'd2,3'd2,3'd2,3'd4,3'd3,3'd2,3'd1,3'd1}, ramp(1'b1), 1, 2};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst in_ready", int'(w5_in_ready), 1);
        chk("rst out_valid", int'(w5_out_valid), 0);
        chk("rst out_class", int'(w5_class), 0);
        chk("rst out_votes", int'(w5_votes), 0);
        chk("rst k4 in_ready", int'(w4_in_ready), 1);
        chk("rst k4 out_valid", int'(w4_out_valid), 0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 7; i++)
            run5(tbl[i].asc, tbl[i].ty, tbl[i].d, tbl[i].cls, tbl[i].votes,
                 $sformatf("tbl%0d", i), 0);

        // K=4 tie: distances decide under the macro, index otherwise
        v4_asc = 1'b1;
        v4_type = {3'd7,3'd7,3'd7,3'd7,3'd1,3'd4,3'd4,3'd1};
        v4_in = {16'd90,16'd80,16'd70,16'd60,16'd40,16'd13,16'd12,16'd10};
        v4_in_valid = 1'b1;
        chk("k4 ready", int'(w4_in_ready), 1);
        @(posedge clk); #1;
        v4_in_valid = 1'b0;
        cyc = 1;
        while (!w4_out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
        chk("k4 latency", cyc, 13);
`ifdef TIE_BREAK_DIST_EN
        chk("k4 class", int'(w4_class), 4);
`else
        chk("k4 class", int'(w4_class), 1);
`endif
        chk("k4 votes", int'(w4_votes), 2);
        v4_out_ready = 1'b1;
        @(posedge clk); #1;
        v4_out_ready = 1'b0;
        chk("k4 valid drop", int'(w4_out_valid), 0);

        // Back-pressure: stalled result stays put, new vector is ignored
        run5(tbl[0].asc, tbl[0].ty, tbl[0].d, 2, 3, "stall pre", 0);
        v5_asc = 1'b1; v5_type = tbl[0].ty; v5_in = tbl[0].d; v5_in_valid = 1'b1;
        @(posedge clk); #1;
        v5_in_valid = 1'b0;
        cyc = 1;
        while (!w5_out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
        chk("stall latency", cyc, 14);
        v5_in_valid = 1'b1; v5_type = 24'hFFFFFF; v5_asc = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("stall valid", int'(w5_out_valid), 1);
            chk("stall class", int'(w5_class), 2);
            chk("stall votes", int'(w5_votes), 3);
            chk("stall in_ready", int'(w5_in_ready), 0);
            @(posedge clk); #1;
        end
        v5_in_valid = 1'b0;
        v5_out_ready = 1'b1;
        @(posedge clk); #1;
        v5_out_ready = 1'b0;
        chk("stall release valid", int'(w5_out_valid), 0);
        chk("stall release ready", int'(w5_in_ready), 1);
        @(posedge clk); #1;
        chk("stall no capture", int'(w5_in_ready), 1);

        // Reset during COUNT
        v5_asc = 1'b1; v5_type = 24'hFFFFFF; v5_in = ramp(1'b1); v5_in_valid = 1'b1;
        @(posedge clk); #1;
        v5_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("midrst out_valid", int'(w5_out_valid), 0);
        chk("midrst in_ready", int'(w5_in_ready), 1);
        chk("midrst out_class", int'(w5_class), 0);
        chk("midrst out_votes", int'(w5_votes), 0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        run5(tbl[0].asc, tbl[0].ty, tbl[0].d, 2, 3, "post rst", 0);

        // Back-to-back with in_valid held high
        v5_asc = 1'b1; v5_type = tbl[0].ty; v5_in = ramp(1'b1); v5_in_valid = 1'b1;
        guard = 0;
        while (!w5_in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        v5_type = 24'hFFFFFF;
        cyc = 1;
        while (!w5_out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
        chk("b2b first latency", cyc, 14);
        chk("b2b first class", int'(w5_class), 2);
        chk("b2b first votes", int'(w5_votes), 3);
        v5_out_ready = 1'b1;
        @(posedge clk); #1;
        chk("b2b idle valid", int'(w5_out_valid), 0);
        chk("b2b idle ready", int'(w5_in_ready), 1);
        @(posedge clk); #1;
        v5_in_valid = 1'b0;
        v5_out_ready = 1'b0;
        chk("b2b second captured", int'(w5_in_ready), 0);
        cyc = 1;
        while (!w5_out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
        chk("b2b second latency", cyc, 14);
        chk("b2b second class", int'(w5_class), 7);
        chk("b2b second votes", int'(w5_votes), 5);
        v5_out_ready = 1'b1;
        @(posedge clk); #1;
        v5_out_ready = 1'b0;
        chk("b2b done", int'(w5_out_valid), 0);

        // Random vectors against the reference model
        for (int i = 0; i < 30; i++) begin
            bit           asc;
            logic [23:0]  ty;
            logic [127:0] d;
            asc = 1'($urandom_range(0, 1));
            ty = 24'($urandom);
            d = {$urandom, $urandom, $urandom, $urandom};
            model(asc, ty, d, 5, ec, ev);
            run5(asc, ty, d, ec, ev, $sformatf("rnd%0d", i), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
